bus_sequencer: RTL and testbench

Moore-style control sequencer for the single shared 32-bit datapath bus. It runs the fetch/decode/execute steps for each instruction by driving the bus-source selects and the register load enables in order. It guarantees that no more than one bus source is selected in any cycle, so the bus priority encoder never has to resolve a conflict. It sits between the IR output, the memory-ready handshake and the bus/register file/ALU.

---
 rtl/bus_sequencer_pkg.sv | 55 +++++
 rtl/bus_sequencer_field_decoder.sv | 21 ++
 rtl/bus_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer: opcodes, state encoding, IR field
// positions and the opcode-to-execute-class mapping.
package bus_sequencer_pkg;

    localparam int OP_MSB = 31;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'b01100;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_MULDIV, C_LD, C_ST, C_IN, C_OUT,
        C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } op_class_e;

    typedef enum logic [1:0] {F_RA, F_RB, F_RC} field_e;

    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cls;
        case (op) inside
            OP_LD:                     cls = C_LD;
            OP_ST:                     cls = C_ST;
            OP_LDI, [OP_ADDI:OP_ORI]:  cls = C_IMM;
            [5'b00011:5'b01011]:       cls = C_ALU;
            OP_DIV, OP_MUL:            cls = C_MULDIV;
            OP_IN:                     cls = C_IN;
            OP_OUT:                    cls = C_OUT;
            OP_MFHI:                   cls = C_MFHI;
            OP_MFLO:                   cls = C_MFLO;
            OP_NOP:                    cls = C_NOP;
            OP_HALT:                   cls = C_HALT;
            default:                   cls = C_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/bus_sequencer_field_decoder.sv
// Register-field decoder: binary field to one-hot select, all-zero when disabled.
module field_decoder #(
    parameter int W = 4,
    parameter int N = 16
) (
    input  logic         en,
    input  logic [W-1:0] sel,
    output logic [N-1:0] onehot
);

    // One-hot expansion of the selected field
    always_comb begin
        onehot = {N{1'b0}};
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {N{1'b0}};
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Moore control sequencer for the shared datapath bus: steps fetch/decode/execute
// and drives at most one bus source per cycle.
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic [NREG-1:0] reg_out,
    output logic            hi_out,
    output logic            lo_out,
    output logic            zhi_out,
    output logic            zlo_out,
    output logic            pc_out,
    output logic            mdr_out,
    output logic            iport_out,
    output logic            c_out,
    output logic [NREG-1:0] reg_in,
    output logic            pc_in,
    output logic            inc_pc,
    output logic            ir_in,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            mdr_rd,
    output logic            y_in,
    output logic            z_in,
    output logic            hi_in,
    output logic            lo_in,
    output logic            oport_in,
    output logic            mem_read,
    output logic            mem_write,
    output logic [OPW-1:0]  alu_op,
    output logic            run,
    output logic            illegal
);

    localparam int FW = $clog2(NREG);

    state_e          state_r;
    state_e          next_state_s;
    op_class_e       cls_s;
    logic [OPW-1:0]  opcode_s;
    logic [FW-1:0]   ra_s;
    logic [FW-1:0]   rb_s;
    logic [FW-1:0]   rc_s;
    logic [FW-1:0]   src_idx_s;
    field_e          src_fld_s;
    logic            src_en_s;
    logic            dst_en_s;
    logic            unused_ir_s;

    assign opcode_s    = ir[OP_MSB -: OPW];
    assign ra_s        = ir[RA_LSB +: FW];
    assign rb_s        = ir[RB_LSB +: FW];
    assign rc_s        = ir[RC_LSB +: FW];
    assign cls_s       = classify(opcode_s);
    assign unused_ir_s = ^ir[RC_LSB-1:0];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_T0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing; T1, ld T6 and st T7 hold until mem_ready
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_T0: next_state_s = S_T1;
            S_T1: next_state_s = mem_ready ? S_T2 : S_T1;
            S_T2: next_state_s = S_T3;
            S_T3: begin
                case (cls_s)
                    C_ALU, C_IMM, C_MULDIV, C_LD, C_ST: next_state_s = S_T4;
                    C_HALT:                             next_state_s = S_HALT;
                    default:                            next_state_s = S_T0;
                endcase
            end
            S_T4: next_state_s = S_T5;
            S_T5: begin
                if (cls_s == C_MULDIV || cls_s == C_LD || cls_s == C_ST) begin
                    next_state_s = S_T6;
                end else begin
                    next_state_s = S_T0;
                end
            end
            S_T6: begin
                case (cls_s)
                    C_LD:    next_state_s = mem_ready ? S_T7 : S_T6;
                    C_ST:    next_state_s = S_T7;
                    default: next_state_s = S_T0;
                endcase
            end
            S_T7: begin
                if (cls_s == C_ST && !mem_ready) begin
                    next_state_s = S_T7;
                end else begin
                    next_state_s = S_T0;
                end
            end
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_T0;
        endcase
    end

    // Output decode of state and IR; each state names at most one bus source
    always_comb begin
        {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out} = 8'b0;
        {pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_rd, y_in, z_in} = 8'b0;
        {hi_in, lo_in, oport_in, mem_read, mem_write} = 5'b0;
        alu_op    = opcode_s;
        run       = 1'b1;
        illegal   = 1'b0;
        src_en_s  = 1'b0;
        src_fld_s = F_RA;
        dst_en_s  = 1'b0;
        case (state_r)
            S_T0: begin
                {pc_out, mar_in, inc_pc, z_in} = 4'b1111;
                alu_op = ALU_ADD;
            end
            S_T1: {zlo_out, pc_in, mem_read, mdr_rd, mdr_in} = 5'b11111;
            S_T2: {mdr_out, ir_in} = 2'b11;
            S_T3: begin
                case (cls_s)
                    C_ALU, C_IMM, C_LD, C_ST: begin
                        src_en_s  = 1'b1;
                        src_fld_s = F_RB;
                        y_in      = 1'b1;
                        if (cls_s == C_LD || cls_s == C_ST) begin
                            alu_op = ALU_ADD;
                        end else begin
                            alu_op = opcode_s;
                        end
                    end
                    C_MULDIV: {src_en_s, y_in} = 2'b11;
                    C_IN:     {iport_out, dst_en_s} = 2'b11;
                    C_OUT:    {src_en_s, oport_in} = 2'b11;
                    C_MFHI:   {hi_out, dst_en_s} = 2'b11;
                    C_MFLO:   {lo_out, dst_en_s} = 2'b11;
                    C_ILL:    illegal = 1'b1;
                    default:  illegal = 1'b0;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    C_ALU: begin
                        src_en_s  = 1'b1;
                        src_fld_s = F_RC;
                        z_in      = 1'b1;
                    end
                    C_IMM:        {c_out, z_in} = 2'b11;
                    C_LD, C_ST: begin
                        {c_out, z_in} = 2'b11;
                        alu_op        = ALU_ADD;
                    end
                    C_MULDIV: begin
                        src_en_s  = 1'b1;
                        src_fld_s = F_RB;
                        z_in      = 1'b1;
                    end
                    default: z_in = 1'b0;
                endcase
            end
            S_T5: begin
                case (cls_s)
                    C_ALU, C_IMM: {zlo_out, dst_en_s} = 2'b11;
                    C_MULDIV:     {zlo_out, lo_in} = 2'b11;
                    C_LD, C_ST:   {zlo_out, mar_in} = 2'b11;
                    default:      zlo_out = 1'b0;
                endcase
            end
            S_T6: begin
                case (cls_s)
                    C_MULDIV: {zhi_out, hi_in} = 2'b11;
                    C_LD:     {mem_read, mdr_rd, mdr_in} = 3'b111;
                    C_ST:     {src_en_s, mdr_in} = 2'b11;
                    default:  mdr_in = 1'b0;
                endcase
            end
            S_T7: begin
                case (cls_s)
                    C_LD:    {mdr_out, dst_en_s} = 2'b11;
                    C_ST:    mem_write = 1'b1;
                    default: mem_write = 1'b0;
                endcase
            end
            S_HALT: begin
                run    = 1'b0;
                alu_op = {OPW{1'b0}};
            end
            default: run = 1'b1;
        endcase
    end

    // Field mux feeding the bus-source register decoder
    always_comb begin
        case (src_fld_s)
            F_RA:    src_idx_s = ra_s;
            F_RB:    src_idx_s = rb_s;
            F_RC:    src_idx_s = rc_s;
            default: src_idx_s = ra_s;
        endcase
    end

    field_decoder #(.W(FW), .N(NREG)) u_src_dec (
        .en     (src_en_s),
        .sel    (src_idx_s),
        .onehot (reg_out)
    );

    field_decoder #(.W(FW), .N(NREG)) u_dst_dec (
        .en     (dst_en_s),
        .sel    (ra_s),
        .onehot (reg_in)
    );

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer.
module tb_bus_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] reg_out, reg_in;
    logic        hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out;
    logic        pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_rd, y_in, z_in;
    logic        hi_in, lo_in, oport_in, mem_read, mem_write, run, illegal;
    logic [4:0]  alu_op;
    logic [20:0] ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [20:0] HI_OUT  = 21'h100000, LO_OUT   = 21'h080000;
    localparam logic [20:0] ZHI_OUT = 21'h040000, ZLO_OUT  = 21'h020000;
    localparam logic [20:0] PC_OUT  = 21'h010000, MDR_OUT  = 21'h008000;
    localparam logic [20:0] IPORT   = 21'h004000, C_OUT    = 21'h002000;
    localparam logic [20:0] PC_IN   = 21'h001000, INC_PC   = 21'h000800;
    localparam logic [20:0] IR_IN   = 21'h000400, MAR_IN   = 21'h000200;
    localparam logic [20:0] MDR_IN  = 21'h000100, MDR_RD   = 21'h000080;
    localparam logic [20:0] Y_IN    = 21'h000040, Z_IN     = 21'h000020;
    localparam logic [20:0] HI_IN   = 21'h000010, LO_IN    = 21'h000008;
    localparam logic [20:0] OPORT   = 21'h000004, MEM_RD   = 21'h000002;
    localparam logic [20:0] MEM_WR  = 21'h000001, NONE     = 21'h000000;
    localparam logic [20:0] T0V = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [20:0] T1V = ZLO_OUT | PC_IN | MEM_RD | MDR_RD | MDR_IN;
    localparam logic [20:0] T2V = MDR_OUT | IR_IN;

    assign ctl = {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out,
                  pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_rd, y_in, z_in,
                  hi_in, lo_in, oport_in, mem_read, mem_write};

    always #5 clock = ~clock;

    bus_sequencer #(.OPW(5), .NREG(16)) dut (
        .clock(clock), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
        .reg_out(reg_out), .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out),
        .zlo_out(zlo_out), .pc_out(pc_out), .mdr_out(mdr_out), .iport_out(iport_out),
        .c_out(c_out), .reg_in(reg_in), .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_rd(mdr_rd), .y_in(y_in), .z_in(z_in),
        .hi_in(hi_in), .lo_in(lo_in), .oport_in(oport_in), .mem_read(mem_read),
        .mem_write(mem_write), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    task automatic do_reset();
        @(negedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctl !== T0V) begin errors++; $display("FAIL reset_ctl got %h want %h", ctl, T0V); end
        checks++;
        if (reg_out !== 16'h0 || reg_in !== 16'h0) begin
            errors++; $display("FAIL reset_regsel got %h/%h want 0/0", reg_out, reg_in);
        end
        checks++;
        if (run !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_run got %b/%b want 1/0", run, illegal);
        end
        checks++;
        if (alu_op !== 5'b01100) begin errors++; $display("FAIL reset_alu got %b want 01100", alu_op); end
    endtask

    task automatic test_add();
        logic [20:0] ec [7] = '{T0V, T1V, T2V, Y_IN, Z_IN, ZLO_OUT, T0V};
        logic [15:0] er [7] = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0010, 16'h0, 16'h0};
        logic [15:0] ei [7] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0};
        ir = {5'b00011, 4'd1, 4'd2, 4'd4, 15'd0};
        mem_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clock);
            checks++;
            if (ctl !== ec[c]) begin errors++; $display("FAIL add_ctl c%0d got %h want %h", c, ctl, ec[c]); end
            checks++;
            if (reg_out !== er[c]) begin errors++; $display("FAIL add_regout c%0d got %h want %h", c, reg_out, er[c]); end
            checks++;
            if (reg_in !== ei[c]) begin errors++; $display("FAIL add_regin c%0d got %h want %h", c, reg_in, ei[c]); end
            if (c == 4) begin
                checks++;
                if (alu_op !== 5'b00011) begin errors++; $display("FAIL add_alu got %b want 00011", alu_op); end
            end
        end
    endtask

    task automatic test_ld_waits();
        logic [20:0] ec [15] = '{T0V, T1V, T1V, T1V, T1V, T2V, Y_IN, C_OUT | Z_IN,
                                 ZLO_OUT | MAR_IN, MEM_RD | MDR_RD | MDR_IN,
                                 MEM_RD | MDR_RD | MDR_IN, MEM_RD | MDR_RD | MDR_IN,
                                 MEM_RD | MDR_RD | MDR_IN, MDR_OUT, T0V};
        ir = {5'b00000, 4'd3, 4'd5, 19'd0};
        mem_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clock);
            checks++;
            if (ctl !== ec[c]) begin errors++; $display("FAIL ld_ctl c%0d got %h want %h", c, ctl, ec[c]); end
            checks++;
            if (reg_out !== ((c == 6) ? 16'h0020 : 16'h0)) begin
                errors++; $display("FAIL ld_regout c%0d got %h", c, reg_out);
            end
            checks++;
            if (reg_in !== ((c == 13) ? 16'h0008 : 16'h0)) begin
                errors++; $display("FAIL ld_regin c%0d got %h", c, reg_in);
            end
            if (c == 7) begin
                checks++;
                if (alu_op !== 5'b01100) begin errors++; $display("FAIL ld_alu got %b want 01100", alu_op); end
            end
            mem_ready = (c == 4 || c == 12);
        end
    endtask

    task automatic test_mul();
        logic [20:0] ec [8] = '{T0V, T1V, T2V, Y_IN, Z_IN, ZLO_OUT | LO_IN, ZHI_OUT | HI_IN, T0V};
        logic [15:0] er [8] = '{16'h0, 16'h0, 16'h0, 16'h0040, 16'h0080, 16'h0, 16'h0, 16'h0};
        ir = {5'b10000, 4'd6, 4'd7, 19'd0};
        mem_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clock);
            checks++;
            if (ctl !== ec[c]) begin errors++; $display("FAIL mul_ctl c%0d got %h want %h", c, ctl, ec[c]); end
            checks++;
            if (reg_out !== er[c] || reg_in !== 16'h0) begin
                errors++; $display("FAIL mul_regsel c%0d got %h/%h want %h/0", c, reg_out, reg_in, er[c]);
            end
            if (c == 4) begin
                checks++;
                if (alu_op !== 5'b10000) begin errors++; $display("FAIL mul_alu got %b want 10000", alu_op); end
            end
        end
    endtask

    task automatic test_halt();
        logic [20:0] ec [4] = '{T0V, T1V, T2V, NONE};
        logic [20:0] want;
        ir = 32'hD800_0000;
        mem_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clock);
            want = (c < 4) ? ec[c] : NONE;
            checks++;
            if (ctl !== want || reg_out !== 16'h0 || reg_in !== 16'h0) begin
                errors++; $display("FAIL halt_out c%0d got %h/%h/%h want %h/0/0", c, ctl, reg_out, reg_in, want);
            end
            checks++;
            if (run !== (c < 4) || illegal !== 1'b0) begin
                errors++; $display("FAIL halt_run c%0d got %b/%b want %b/0", c, run, illegal, c < 4);
            end
            mem_ready = c[0];
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (ctl !== T0V || run !== 1'b1) begin
            errors++; $display("FAIL halt_reset got %h/%b want %h/1", ctl, run, T0V);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_illegal();
        logic [20:0] ec [5] = '{T0V, T1V, T2V, NONE, T0V};
        ir = {5'b11111, 27'd0};
        mem_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clock);
            checks++;
            if (ctl !== ec[c]) begin errors++; $display("FAIL ill_ctl c%0d got %h want %h", c, ctl, ec[c]); end
            checks++;
            if (illegal !== (c == 3)) begin
                errors++; $display("FAIL ill_flag c%0d got %b want %b", c, illegal, c == 3);
            end
        end
    endtask

    task automatic test_reset_mid_st();
        logic [20:0] ec [9] = '{T0V, T1V, T2V, Y_IN, C_OUT | Z_IN, ZLO_OUT | MAR_IN,
                                MDR_IN, MEM_WR, MEM_WR};
        ir = {5'b00010, 4'd2, 4'd1, 19'd0};
        mem_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clock);
            checks++;
            if (ctl !== ec[c]) begin errors++; $display("FAIL st_ctl c%0d got %h want %h", c, ctl, ec[c]); end
            if (c == 6) begin
                checks++;
                if (reg_out !== 16'h0004) begin errors++; $display("FAIL st_regout got %h want 0004", reg_out); end
            end
            mem_ready = (c < 5);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || ctl !== T0V) begin
            errors++; $display("FAIL st_async_reset got %b/%h want 0/%h", mem_write, ctl, T0V);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random_onehot();
        int n;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            n = $countones(reg_out) + $countones(ctl[20:13]);
            checks++;
            if (n > 1 || $countones(reg_in) > 1) begin
                errors++; $display("FAIL onehot c%0d sources %0d regin %h", c, n, reg_in);
            end
            ir = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            if (run == 1'b0 || $urandom_range(0, 499) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ir = 32'h0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_ld_waits();
        test_mul();
        test_halt();
        test_illegal();
        test_reset_mid_st();
        test_random_onehot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
